// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS31 polynomial constants, stream defaults, FSM encoding and the 32-step LFSR helper
package prbs_pkg;
  localparam int PRBS_LEN = 31;
  localparam int PRBS_TAP = 28;
  localparam int WORD_W = 32;
  localparam logic [1:0] VLDB_ALL = 2'b00;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
  // Runs WORD_W serial steps of x^31+x^28+1; bit i of the word is the inverted feedback of step i.
  // Returns {next_state, word}.
  function automatic logic [PRBS_LEN+WORD_W-1:0] prbs31_adv(input logic [PRBS_LEN-1:0] s);
    logic [PRBS_LEN-1:0] r;
    logic [WORD_W-1:0] w;
    logic fb;
    r = s;
    w = '0;
    for (int i = 0; i < WORD_W; i++) begin
      fb = r[PRBS_LEN-1] ^ r[PRBS_TAP-1];
      w[i] = ~fb;
      r = {r[PRBS_LEN-2:0], fb};
    end
    return {r, w};
  endfunction
endpackage

// File: rtl/prbs31_par_gen.sv
// prbs31_par_gen: PRBS31 LFSR presenting the next 32-bit word combinationally, advanced one word per adv_i
module prbs31_par_gen
  import prbs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PRBS_LEN-1:0] seed,
  input  logic                adv_i,
  output logic [WORD_W-1:0]   word_o
);
  logic [PRBS_LEN-1:0] lfsr, lfsr_nxt;
  // Precompute the next word and the state 32 steps ahead so a word is ready every cycle
  always_comb {lfsr_nxt, word_o} = prbs31_adv(lfsr);
  // State only moves when the word is consumed; reset reloads the seed
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= seed;
    else if (adv_i) lfsr <= lfsr_nxt;
endmodule

// File: rtl/prbs_pkt_gen.sv
// prbs_pkt_gen: framed PRBS31 packet source with valid/ready flow control; PRBS_ERR_INJ_EN adds err_inj_i single-bit error injection
module prbs_pkt_gen
  import prbs_pkg::*;
#(
  parameter int                  PKT_LEN    = 256,
  parameter int                  GAP_CYCLES = 4,
  parameter logic [PRBS_LEN-1:0] SEED       = 31'h7FFF_FFFF
) (
  input  logic        tx_user_clk_i,
  input  logic        tx_user_rst_i,
  input  logic        gen_en_i,
  input  logic        tx_ready_i,
`ifdef PRBS_ERR_INJ_EN
  input  logic        err_inj_i,
`endif
  output logic [31:0] tx_data_o,
  output logic [1:0]  tx_vldb_o,
  output logic        tx_valid_o,
  output logic        tx_last_o,
  output logic        tx_user_o,
  output logic [31:0] pkt_cnt_o,
  output logic        busy_o
);
  state_t state, state_d;
  logic [7:0] beat, beat_nxt, gap_cnt;
  logic [31:0] word;
  logic xfer, last_xfer, gap_done, start, load, inj;

  assign xfer = tx_valid_o & tx_ready_i;
  assign last_xfer = xfer & tx_last_o;
  assign gap_done = gap_cnt == 8'(GAP_CYCLES - 1);
  assign load = start | (xfer & ~tx_last_o);
  assign beat_nxt = start ? 8'd0 : beat + 8'd1;
  assign tx_valid_o = state == SEND;
  assign busy_o = state != IDLE;
  assign tx_vldb_o = VLDB_ALL;

  prbs31_par_gen u_prbs (
    .clk    (tx_user_clk_i),
    .rst    (tx_user_rst_i),
    .seed   (SEED),
    .adv_i  (load),
    .word_o (word)
  );

  // Next state; start marks loading beat 0 of a new packet
  always_comb begin
    state_d = state;
    start = 1'b0;
    case (state)
      IDLE: begin
        start = gen_en_i;
        state_d = gen_en_i ? SEND : IDLE;
      end
      SEND: if (last_xfer) begin
        start = (GAP_CYCLES == 0) && gen_en_i;
        state_d = GAP_CYCLES > 0 ? GAP : gen_en_i ? SEND : IDLE;
      end
      GAP: if (gap_done) begin
        start = gen_en_i;
        state_d = gen_en_i ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i)
    if (tx_user_rst_i) state <= IDLE;
    else state <= state_d;

  // Beat index of the word on the bus and elapsed gap cycles
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i)
    if (tx_user_rst_i) begin
      beat <= 8'd0;
      gap_cnt <= 8'd0;
    end else begin
      if (load) beat <= beat_nxt;
      gap_cnt <= state == GAP ? gap_cnt + 8'd1 : 8'd0;
    end

  // Output beat register; only reloads when empty or the held beat transfers, so stalls keep it stable
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i)
    if (tx_user_rst_i) begin
      tx_data_o <= 32'd0;
      tx_user_o <= 1'b0;
      tx_last_o <= 1'b0;
    end else if (load) begin
      tx_data_o <= word ^ {31'd0, inj};
      tx_user_o <= start;
      tx_last_o <= beat_nxt == 8'(PKT_LEN - 1);
    end

  // Completed packets, counted when the last beat is accepted
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i)
    if (tx_user_rst_i) pkt_cnt_o <= 32'd0;
    else if (last_xfer) pkt_cnt_o <= pkt_cnt_o + 32'd1;

`ifdef PRBS_ERR_INJ_EN
  logic armed;
  assign inj = armed | err_inj_i;
  // Pending injection waits for the next loaded beat; pulses before that merge into one
  always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i)
    if (tx_user_rst_i) armed <= 1'b0;
    else armed <= load ? 1'b0 : inj;
`else
  assign inj = 1'b0;
`endif
endmodule
